// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with valid/ready on both sides, carry/zero flags and a
// multi-cycle shift-add unsigned multiply (opcode 15).
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int BW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       inst,
  input  logic [BW-1:0]    bit_number,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ansf,
  output logic             carry,
  output logic             zero
);

  localparam int H = WIDTH / 2;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef enum logic [3:0] {
    OP_PASSB = 4'd0,  OP_PASSA = 4'd1,  OP_ADD  = 4'd2,  OP_SUB  = 4'd3,
    OP_AND   = 4'd4,  OP_INC   = 4'd5,  OP_DEC  = 4'd6,  OP_XOR  = 4'd7,
    OP_NOP   = 4'd8,  OP_CLR   = 4'd9,  OP_OR   = 4'd10, OP_SWAP = 4'd11,
    OP_NOT   = 4'd12, OP_BSET  = 4'd13, OP_BCLR = 4'd14, OP_MUL  = 4'd15
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] val;
    logic             cy;
  } res_t;

  state_t             state;
  logic [WIDTH-1:0]   ma, mb;
  logic [2*WIDTH-1:0] prod, prod_nxt;
  logic [BW-1:0]      cnt;

  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   mask;
  res_t               alu;

  // Single-cycle datapath; NOP falls through with the registered result.
  always_comb begin
    mask = (32'(bit_number) < 32'(WIDTH)) ? (WIDTH'(1) << bit_number) : '0;
    ext  = '0;
    alu  = '{val: ansf, cy: carry};
    case (op_e'(inst))
      OP_PASSB: alu = '{b, 1'b0};
      OP_PASSA: alu = '{a, 1'b0};
      OP_ADD: begin
        ext = {1'b0, a} + {1'b0, b};
        alu = '{ext[WIDTH-1:0], ext[WIDTH]};
      end
      OP_SUB: begin
        ext = {1'b0, b} - {1'b0, a};
        alu = '{ext[WIDTH-1:0], ext[WIDTH]};
      end
      OP_AND:  alu = '{a & b, 1'b0};
      OP_INC: begin
        ext = {1'b0, b} + 1'b1;
        alu = '{ext[WIDTH-1:0], ext[WIDTH]};
      end
      OP_DEC: begin
        ext = {1'b0, b} - 1'b1;
        alu = '{ext[WIDTH-1:0], ext[WIDTH]};
      end
      OP_XOR:  alu = '{a ^ b, 1'b0};
      OP_CLR:  alu = '{'0, 1'b0};
      OP_OR:   alu = '{a | b, 1'b0};
      OP_SWAP: alu = '{(b << H) | (b >> (WIDTH - H)), 1'b0};
      OP_NOT:  alu = '{~b, 1'b0};
      OP_BSET: alu = '{b | mask, 1'b0};
      OP_BCLR: alu = '{b & ~mask, 1'b0};
      default: alu = '{ansf, carry};
    endcase
  end

  // One partial product per MUL cycle, multiplier bit selected by cnt.
  always_comb begin
    prod_nxt = prod;
    if (mb[cnt])
      prod_nxt = prod + ({{WIDTH{1'b0}}, ma} << cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ansf      <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      ma        <= '0;
      mb        <= '0;
      prod      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (op_e'(inst) == OP_MUL) begin
              state <= MUL;
              ma    <= a;
              mb    <= b;
              prod  <= '0;
              cnt   <= '0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              ansf      <= alu.val;
              carry     <= alu.cy;
              zero      <= (alu.val == '0);
            end
          end
        end
        MUL: begin
          prod <= prod_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == BW'(WIDTH - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            ansf      <= prod_nxt[WIDTH-1:0];
            carry     <= |prod_nxt[2*WIDTH-1:WIDTH];
            zero      <= (prod_nxt[WIDTH-1:0] == '0);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
